// File: rtl/switch_debounce_sync_pkg.sv
// Shared constants for the slide-switch conditioner: counter sizing, the
// hardware debounce length, and the short length used in simulation.
package switch_debounce_sync_pkg;

  localparam int CNT_W_DEFAULT           = 24;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int SIM_DEBOUNCE_CYCLES     = 4;
  localparam int DEBOUNCE_MIN            = 2;
  localparam int DEBOUNCE_MAX            = 1 << 24;

  // True when a counter of the given width can represent every count 0..cycles-1.
  function automatic bit cnt_fits(input int cycles, input int width);
    return (longint'(1) << width) >= longint'(cycles);
  endfunction

endpackage

// File: rtl/switch_debounce_sync_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, accepted level
// and registered rise/fall strobes.
module debounce_bit
  import switch_debounce_sync_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // High on the edge where a persistent difference is finally taken as the new level.
  assign accept = (sync2 != stable) && (cnt == LAST);
  assign clean  = stable;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync2;
        cnt    <= '0;
        rise   <= sync2;
        fall   <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_debounce_sync.sv
// Conditions the raw slide switches into clean levels plus one-cycle edge
// strobes; sw_clean replaces raw SW at the mux datapath inputs.
module switch_debounce_sync
  import switch_debounce_sync_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             any_change
);

  // Reject parameter sets the counter cannot honour, at elaboration time.
  if (DEBOUNCE_CYCLES < DEBOUNCE_MIN || DEBOUNCE_CYCLES > DEBOUNCE_MAX ||
      !cnt_fits(DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_param
    $error("switch_debounce_sync: DEBOUNCE_CYCLES=%0d illegal for CNT_W=%0d",
           DEBOUNCE_CYCLES, CNT_W);
  end

  logic [WIDTH-1:0] accept;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk   (CLOCK_50),
      .resetn(resetn),
      .raw   (sw_raw[gi]),
      .clean (sw_clean[gi]),
      .rise  (sw_rise[gi]),
      .fall  (sw_fall[gi]),
      .accept(accept[gi])
    );
  end

  // Registered from the same acceptance condition, so it lands with the strobes.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |accept;
    end
  end

endmodule
